// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and default constants for the bouncing sprite engine.
//   color_t : 12-bit RGB pixel (4 bits per channel)
//   dir_t   : per-axis travel direction (POS = increasing coordinate)
package sprite_pkg;

  typedef logic [11:0] color_t;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  localparam int     H_ACTIVE_DEF  = 640;
  localparam int     V_ACTIVE_DEF  = 480;
  localparam color_t KEY_COLOR_DEF = 12'hF0F;
  localparam color_t BG_COLOR_DEF  = 12'hFFF;

endpackage

// File: rtl/sprite_motion.sv
// sprite_motion
//   One axis of sprite movement: a position register plus a two-state
//   direction FSM that bounces the sprite between 0 and LIMIT-SIZE.
//   Ports:
//     clock, reset : system clock, synchronous active-high reset
//     tick         : one-cycle frame pulse; the only time position may move
//     move_en      : 1 = step on tick, 0 = hold position and direction
//     pos          : current top-left coordinate on this axis
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 256,
  parameter int VEL   = 2,
  parameter int START = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       move_en,
  output logic [9:0] pos
);

  // 11-bit working width so pos+VEL+SIZE never wraps before the compare
  localparam logic [10:0] LIMIT_EXT = 11'(LIMIT);
  localparam logic [10:0] SIZE_EXT  = 11'(SIZE);
  localparam logic [10:0] VEL_EXT   = 11'(VEL);
  localparam logic [9:0]  MAX_POS   = 10'(LIMIT - SIZE);

  logic [9:0]  pos_q, pos_d;
  dir_t        dir_q, dir_d;
  logic [10:0] pos_ext;

  assign pos_ext = {1'b0, pos_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q <= 10'(START);
      dir_q <= POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  // Overshooting an edge clamps to that edge and reverses, so when
  // SIZE==LIMIT the axis sits at 0 and simply toggles direction.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick && move_en) begin
      case (dir_q)
        POS: begin
          if (pos_ext + VEL_EXT + SIZE_EXT > LIMIT_EXT) begin
            pos_d = MAX_POS;
            dir_d = NEG;
          end else begin
            pos_d = pos_q + 10'(VEL);
          end
        end
        NEG: begin
          if (pos_ext < VEL_EXT) begin
            pos_d = '0;
            dir_d = POS;
          end else begin
            pos_d = pos_q - 10'(VEL);
          end
        end
        default: begin
          pos_d = pos_q;
          dir_d = POS;
        end
      endcase
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/sprite_engine.sv
// sprite_engine
//   Composes a moving sprite over a flat background for a VGA scan.
//   Ports:
//     clock, reset     : pixel clock, synchronous active-high reset
//     move_en          : 1 = sprite advances once per frame
//     HCount, VCount   : current scan position from the VGA driver
//     rom_addr         : sprite ROM address (ROM answers one cycle later)
//     rom_data         : sprite ROM pixel
//     RGB_pixel, hit   : composed pixel and opaque-sprite flag, 2 cycles
//                        after HCount/VCount
//     pos_x, pos_y     : current sprite top-left corner
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int     SPR_W     = 256,
  parameter int     SPR_H     = 256,
  parameter int     ADDR_W    = 16,
  parameter int     H_ACTIVE  = H_ACTIVE_DEF,
  parameter int     V_ACTIVE  = V_ACTIVE_DEF,
  parameter int     VEL_X     = 2,
  parameter int     VEL_Y     = 1,
  parameter int     START_X   = 0,
  parameter int     START_Y   = 0,
  parameter color_t KEY_COLOR = KEY_COLOR_DEF,
  parameter color_t BG_COLOR  = BG_COLOR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              move_en,
  input  logic [9:0]        HCount,
  input  logic [9:0]        VCount,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       RGB_pixel,
  output logic              hit,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y
);

  logic        frame_tick;
  logic        in_win;
  logic [10:0] x_end, y_end;
  logic [9:0]  off_x, off_y;

  logic        in_win_q, in_win_d;
  color_t      rgb_q, rgb_d;
  logic        hit_q, hit_d;

  // First blanking line start: one pulse per frame, outside active video
  assign frame_tick = (HCount == 10'd0) && (VCount == 10'(V_ACTIVE));

  sprite_motion #(
    .LIMIT(H_ACTIVE),
    .SIZE (SPR_W),
    .VEL  (VEL_X),
    .START(START_X)
  ) u_motion_x (
    .clock  (clock),
    .reset  (reset),
    .tick   (frame_tick),
    .move_en(move_en),
    .pos    (pos_x)
  );

  sprite_motion #(
    .LIMIT(V_ACTIVE),
    .SIZE (SPR_H),
    .VEL  (VEL_Y),
    .START(START_Y)
  ) u_motion_y (
    .clock  (clock),
    .reset  (reset),
    .tick   (frame_tick),
    .move_en(move_en),
    .pos    (pos_y)
  );

  assign x_end  = {1'b0, pos_x} + 11'(SPR_W);
  assign y_end  = {1'b0, pos_y} + 11'(SPR_H);
  assign in_win = (HCount >= pos_x) && ({1'b0, HCount} < x_end) &&
                  (VCount >= pos_y) && ({1'b0, VCount} < y_end);

  assign off_x = HCount - pos_x;
  assign off_y = VCount - pos_y;

  // Row-major address, truncated to the ROM width; forced to 0 outside
  assign rom_addr = in_win ? (ADDR_W'(off_y) * ADDR_W'(SPR_W) + ADDR_W'(off_x))
                           : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_win_q <= 1'b0;
      rgb_q    <= BG_COLOR;
      hit_q    <= 1'b0;
    end else begin
      in_win_q <= in_win_d;
      rgb_q    <= rgb_d;
      hit_q    <= hit_d;
    end
  end

  // in_win_q lines up with rom_data; key-coloured sprite pixels show background
  always_comb begin
    in_win_d = in_win;
    rgb_d    = BG_COLOR;
    hit_d    = 1'b0;
    if (in_win_q && (rom_data != KEY_COLOR)) begin
      rgb_d = rom_data;
      hit_d = 1'b1;
    end
  end

  assign RGB_pixel = rgb_q;
  assign hit       = hit_q;

endmodule
